// File: rtl/monoflop_multi.sv
// Monoflop_multi: N independent digital monostables modelled on the '123/'221
// family. Each channel has its own edge detectors, down-counter and registered
// q/q_/done outputs. RETRIG selects retriggerable behaviour for all channels.
module monoflop_multi #(
   parameter int N      = 2,
   parameter int W      = 16,
   parameter int RETRIG = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   a_,
   input  logic [N-1:0]   b,
   input  logic [N-1:0]   clr_,
   input  logic [N*W-1:0] tw,
   output logic [N-1:0]   q,
   output logic [N-1:0]   q_,
   output logic [N-1:0]   done
);

   localparam logic [W-1:0] ONE = W'(1);

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [W-1:0] cnt;
      logic [W-1:0] cntNext;
      logic [W-1:0] twi;
      logic         aP;
      logic         bP;
      logic         clrP;
      logic         armed;
      logic         qReg;
      logic         qnReg;
      logic         doneReg;
      logic         trig;
      logic         fire;
      logic         doneNext;

      assign twi = tw[i*W +: W];

      // Trigger detection and next counter value. The edge history resets to
      // idle levels, so in the first cycle after reset a trigger input that was
      // held active through reset would look like a fresh edge; 'armed' masks
      // that single cycle so a real edge is required after reset.
      always_comb begin
         trig     = armed & ((aP & ~a_[i] & b[i]) |
                             (~bP & b[i] & ~a_[i]) |
                             (~clrP & clr_[i] & ~a_[i] & b[i]));
         fire     = trig & (twi != '0) & ((RETRIG != 0) | (cnt == '0));
         cntNext  = cnt;
         doneNext = 1'b0;
         if (!clr_[i]) begin
            cntNext = '0;
         end else if (fire) begin
            cntNext = twi;
         end else if (cnt != '0) begin
            cntNext  = cnt - ONE;
            doneNext = (cnt == ONE);
         end
      end

      // State registers: reset dominates clear, clear dominates triggers.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt     <= '0;
            qReg    <= 1'b0;
            qnReg   <= 1'b1;
            doneReg <= 1'b0;
            aP      <= 1'b1;
            bP      <= 1'b0;
            clrP    <= 1'b1;
            armed   <= 1'b0;
         end else begin
            cnt     <= cntNext;
            qReg    <= (cntNext != '0);
            qnReg   <= (cntNext == '0);
            doneReg <= doneNext;
            aP      <= a_[i];
            bP      <= b[i];
            clrP    <= clr_[i];
            armed   <= 1'b1;
         end
      end

      assign q[i]    = qReg;
      assign q_[i]   = qnReg;
      assign done[i] = doneReg;
   end

endmodule

// File: tb/tb_monoflop_multi.sv
// Testbench for monoflop_multi: a retriggerable and a non-retriggerable
// instance share stimulus; a pulse-level reference model predicts outputs
// into a queue that a separate monitor drains and compares every cycle.
module tb_monoflop_multi;

   localparam int N = 2;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   aIn;
   logic [N-1:0]   bIn;
   logic [N-1:0]   clrIn;
   logic [N*W-1:0] twIn;
   logic [N-1:0]   qA, qnA, doneA;
   logic [N-1:0]   qB, qnB, doneB;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] qA;
      logic [1:0] dA;
      logic [1:0] qB;
      logic [1:0] dB;
   } expT;

   expT expQ[$];

   // Reference state: remaining pulse cycles per (instance, channel) and the
   // last observed input levels used to recognise edges.
   int   rem [2][N];
   logic mA [N];
   logic mB [N];
   logic mC [N];
   logic mArmed;

   monoflop_multi #(.N(N), .W(W), .RETRIG(1)) dutA (
      .clk(clk), .rst(rst), .a_(aIn), .b(bIn), .clr_(clrIn), .tw(twIn),
      .q(qA), .q_(qnA), .done(doneA)
   );

   monoflop_multi #(.N(N), .W(W), .RETRIG(0)) dutB (
      .clk(clk), .rst(rst), .a_(aIn), .b(bIn), .clr_(clrIn), .tw(twIn),
      .q(qB), .q_(qnB), .done(doneB)
   );

   always #5 clk = ~clk;

   // Predict outputs after the coming rising edge from the pulse rules.
   task automatic modelStep(input logic r, input logic [1:0] a, input logic [1:0] bb,
                            input logic [1:0] c, input logic [15:0] t);
      expT e;
      e = '0;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            int  width;
            logic isTrig;
            logic dn;
            dn = 1'b0;
            width = int'(t[i*W +: W]);
            isTrig = mArmed && ((mA[i] && !a[i] && bb[i]) ||
                                (!mB[i] && bb[i] && !a[i]) ||
                                (!mC[i] && c[i] && !a[i] && bb[i]));
            if (r) begin
               rem[d][i] = 0;
            end else if (!c[i]) begin
               rem[d][i] = 0;
            end else if (isTrig && width > 0 && (d == 0 || rem[d][i] == 0)) begin
               rem[d][i] = width;
            end else if (rem[d][i] > 0) begin
               rem[d][i] = rem[d][i] - 1;
               dn = (rem[d][i] == 0);
            end
            if (d == 0) begin
               e.qA[i] = (rem[d][i] > 0);
               e.dA[i] = dn;
            end else begin
               e.qB[i] = (rem[d][i] > 0);
               e.dB[i] = dn;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         mA[i] = r ? 1'b1 : a[i];
         mB[i] = r ? 1'b0 : bb[i];
         mC[i] = r ? 1'b1 : c[i];
      end
      mArmed = !r;
      expQ.push_back(e);
   endtask

   // Drive one cycle of inputs after the falling edge and record the prediction.
   task automatic applyStimulus(input logic r, input logic [1:0] a, input logic [1:0] bb,
                                input logic [1:0] c, input logic [7:0] t0, input logic [7:0] t1);
      @(negedge clk);
      #1;
      rst   = r;
      aIn   = a;
      bIn   = bb;
      clrIn = c;
      twIn  = {t1, t0};
      modelStep(r, a, bb, c, {t1, t0});
   endtask

   task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, want);
      end
   endtask

   // Monitor: after each rising edge has settled, compare against the oldest prediction.
   initial begin
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            checkOutput("q_retrig",     qA,    e.qA);
            checkOutput("qn_retrig",    qnA,   ~e.qA);
            checkOutput("done_retrig",  doneA, e.dA);
            checkOutput("q_single",     qB,    e.qB);
            checkOutput("qn_single",    qnB,   ~e.qB);
            checkOutput("done_single",  doneB, e.dB);
         end
      end
   end

   initial begin
      rst   = 1'b1;
      aIn   = 2'b11;
      bIn   = 2'b00;
      clrIn = 2'b11;
      twIn  = '0;

      // Reset, then arm b0 high with a_0 idle (no trigger expected).
      repeat (3) applyStimulus(1'b1, 2'b11, 2'b00, 2'b11, 8'd5, 8'd0);
      repeat (2) applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 8'd5, 8'd0);

      // Single 5-cycle pulse on channel 0; channel 1 stays idle.
      applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd5, 8'd0);
      repeat (7) applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd5, 8'd0);

      // Trigger then retrigger three cycles later.
      repeat (2) applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 8'd5, 8'd0);
      applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd5, 8'd0);
      repeat (2) applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 8'd5, 8'd0);
      applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd5, 8'd0);
      repeat (10) applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd5, 8'd0);

      // Clear mid-pulse, then clear release with a_=0, b=1 retriggers.
      applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 8'd8, 8'd0);
      applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd8, 8'd0);
      repeat (2) applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd8, 8'd0);
      repeat (6) applyStimulus(1'b0, 2'b10, 2'b01, 2'b10, 8'd8, 8'd0);
      repeat (11) applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd8, 8'd0);

      // Zero width trigger produces nothing.
      applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 8'd0, 8'd0);
      repeat (4) applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd0, 8'd0);

      // Reset mid-pulse with trigger held across reset release.
      applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 8'd6, 8'd0);
      repeat (3) applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd6, 8'd0);
      applyStimulus(1'b1, 2'b10, 2'b01, 2'b11, 8'd6, 8'd0);
      repeat (4) applyStimulus(1'b0, 2'b10, 2'b01, 2'b11, 8'd6, 8'd0);

      // Both channels at once with different widths.
      applyStimulus(1'b0, 2'b11, 2'b11, 2'b11, 8'd3, 8'd4);
      applyStimulus(1'b0, 2'b00, 2'b11, 2'b11, 8'd3, 8'd4);
      repeat (6) applyStimulus(1'b0, 2'b00, 2'b11, 2'b11, 8'd3, 8'd4);

      // Randomised traffic on both channels.
      for (int k = 0; k < 800; k++) begin
         logic       r;
         logic [1:0] a;
         logic [1:0] bb;
         logic [1:0] c;
         r = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < N; i++) begin
            a[i]  = ($urandom_range(0, 3) != 0);
            bb[i] = ($urandom_range(0, 3) != 0);
            c[i]  = ($urandom_range(0, 19) != 0);
         end
         applyStimulus(r, a, bb, c, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)));
      end

      repeat (3) @(negedge clk);
      #2;
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/monoflop_multi.md
MONOFLOP_MULTI -- requirements
Module: monoflop_multi

Interface
REQ-001 Parameter N, default 2: number of independent monostable channels (1..16).
REQ-002 Parameter W, default 16: pulse-width counter width in bits (2..32).
REQ-003 Parameter RETRIG, default 1: 1 = retriggerable ('123 style), 0 = non-retriggerable ('221 style); applies to all channels.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a_  input  N  per-channel trigger, active low, falling-edge sensitive.
REQ-007 b  input  N  per-channel trigger, active high, rising-edge sensitive.
REQ-008 clr_  input  N  per-channel clear, active low; rising edge also triggers.
REQ-009 tw  input  N*W  per-channel pulse width in clk cycles; channel i uses bits [i*W+W-1:i*W].
REQ-010 q  output  N  per-channel pulse output, registered.
REQ-011 q_  output  N  per-channel complement of q, registered.
REQ-012 done  output  N  per-channel one-cycle strobe at natural pulse end.

Function
REQ-013 Each channel SHALL keep registered copies a_p, b_p, clr_p of the previous-cycle a_, b, clr_ for edge detection.
REQ-014 Trigger SHALL be: (a_p=1, a_=0, b=1) or (b_p=0, b=1, a_=0) or (clr_p=0, clr_=1, a_=0, b=1); all sampled in the same cycle.
REQ-015 Each channel SHALL hold a W-bit down-counter cnt; q=1 exactly when cnt!=0 after the clock edge.
REQ-016 clr_=0 SHALL force cnt=0, q=0, q_=1, done=0 next cycle and SHALL dominate any trigger.
REQ-017 Trigger with cnt=0 and tw!=0 SHALL load cnt=tw (value sampled in the trigger cycle).
REQ-018 Latency: trigger sampled at edge k -> q=1 for edges k+1..k+tw, q=0 at edge k+tw+1; pulse width exactly tw cycles.
REQ-019 Trigger with tw=0 SHALL be ignored: no pulse, no done.
REQ-020 While cnt!=0 and no trigger, cnt SHALL decrement by 1 per cycle.
REQ-021 RETRIG=1: trigger with cnt!=0 SHALL reload cnt=tw; pulse ends tw cycles after the retrigger edge; no done at the reload; q stays 1 without a glitch.
REQ-022 RETRIG=0: trigger with cnt!=0 SHALL be ignored; counting continues.
REQ-023 done SHALL be 1 for exactly the one cycle in which q falls due to cnt reaching 0; not on clear, reset, or tw=0.
REQ-024 Trigger in the same cycle cnt transitions 1->0: RETRIG=1 reloads (q stays 1, no done); RETRIG=0 pulse ends with done, trigger ignored.
REQ-025 tw changes while counting SHALL not affect the running pulse except via a reload.
REQ-026 Channels SHALL be fully independent; no shared state.
REQ-027 q_ SHALL equal ~q in every cycle, including reset.

Reset
REQ-028 rst=1 SHALL set cnt=0, q=0, q_=1, done=0, a_p=1, b_p=0, clr_p=1 on all channels at the next edge.
REQ-029 rst SHALL dominate clr_ and all triggers; a trigger input held across reset release SHALL not fire (edge needed after reset).
REQ-030 rst asserted mid-pulse SHALL terminate the pulse with no done strobe.

Verification
REQ-031 N=2, RETRIG=1, tw0=5: a_0 1->0 with b_0=1 at edge 10 -> q[0]=1 edges 11..15, q[0]=0 and done[0]=1 at edge 16; channel 1 unchanged.
REQ-032 RETRIG=1, tw=5: trigger edge 10, retrigger edge 13 -> q=1 edges 11..18, single done at edge 19.
REQ-033 RETRIG=0, tw=5: triggers at edges 10 and 13 -> q=1 edges 11..15, done at 16.
REQ-034 tw=8, trigger edge 10, clr_=0 at edge 13 -> q=0 from edge 14, no done; clr_ 0->1 at edge 20 with a_=0, b=1 -> q=1 edges 21..28.
REQ-035 tw=0 trigger -> q stays 0, done stays 0; rst at edge 12 during tw=6 pulse from edge 10 -> q=0, q_=1 at edge 13, no done.
